// File: rtl/fifo_uart_tx_if.sv
// Read-side handshake between a single_clock_fifo and the UART transmit stage
// that drains it. The transmitter is the master (it issues the pop strobe).
interface fifo_uart_tx_if #(
  parameter int DATAWIDTH = 8
) ();
  logic                 fifo_read_req;
  logic [DATAWIDTH-1:0] fifo_data;
  logic                 fifo_empty;

  modport master (output fifo_read_req, input fifo_data, input fifo_empty);
  modport slave  (input fifo_read_req, output fifo_data, output fifo_empty);
endinterface

// File: rtl/fifo_uart_tx.sv
// UART transmitter that pops one FIFO word per frame and shifts it out LSB
// first with a start bit and STOP_BITS stop bits; tx is idle high and registered.
module fifo_uart_tx #(
  parameter int DATAWIDTH    = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  fifo_uart_tx_if.master fifo,
  output logic           tx,
  output logic           busy,
  output logic           frame_done
);
  localparam int BAUD_W = $clog2(CLKS_PER_BIT * STOP_BITS);
  localparam int BIT_W  = $clog2(DATAWIDTH + 1);

  localparam logic [BAUD_W-1:0] BIT_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BAUD_W-1:0] STOP_LAST = BAUD_W'(CLKS_PER_BIT * STOP_BITS - 1);
  localparam logic [BAUD_W-1:0] BAUD_ONE  = BAUD_W'(1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATAWIDTH - 1);
  localparam logic [BIT_W-1:0]  BIT_ONE   = BIT_W'(1);

  typedef enum logic [2:0] {IDLE, FETCH, LOAD, START, DATA, STOP} state_t;

  state_t               state, state_d;
  logic [DATAWIDTH-1:0] shreg, shreg_d;
  logic [BAUD_W-1:0]    baud, baud_d;
  logic [BIT_W-1:0]     bit_cnt, bit_cnt_d;
  logic                 tx_d;

  // NOTE: non-blocking assignments here so every register samples the
  // pre-edge values computed by the combinational processes.
  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the datapath registers are reset too, so an abandoned frame
      // leaves no stale word or count behind.
      state   <= IDLE;
      shreg   <= '0;
      baud    <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else begin
      state   <= state_d;
      shreg   <= shreg_d;
      baud    <= baud_d;
      bit_cnt <= bit_cnt_d;
      tx      <= tx_d;
    end
  end

  always_comb begin
    // NOTE: hold-by-default assignments first, so no path leaves a latch.
    state_d   = state;
    shreg_d   = shreg;
    baud_d    = baud;
    bit_cnt_d = bit_cnt;
    unique case (state)
      IDLE:  if (enable && !fifo.fifo_empty) state_d = FETCH;
      FETCH: state_d = LOAD;
      LOAD: begin
        shreg_d   = fifo.fifo_data;
        baud_d    = '0;
        bit_cnt_d = '0;
        state_d   = START;
      end
      START: begin
        if (baud == BIT_LAST) begin
          baud_d  = '0;
          state_d = DATA;
        end else begin
          baud_d = baud + BAUD_ONE;
        end
      end
      DATA: begin
        if (baud == BIT_LAST) begin
          baud_d    = '0;
          shreg_d   = shreg >> 1;
          bit_cnt_d = bit_cnt + BIT_ONE;
          if (bit_cnt == DATA_LAST) state_d = STOP;
        end else begin
          baud_d = baud + BAUD_ONE;
        end
      end
      STOP: begin
        if (baud == STOP_LAST) begin
          baud_d  = '0;
          state_d = IDLE;
        end else begin
          baud_d = baud + BAUD_ONE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // tx is registered, so its next value is derived from the next state.
  always_comb begin
    fifo.fifo_read_req = (state == FETCH);
    busy               = (state != IDLE);
    frame_done         = (state == STOP) && (baud == STOP_LAST);
    unique case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shreg_d[0];
      default: tx_d = 1'b1;
    endcase
  end
endmodule

// File: tb/tb_fifo_uart_tx.sv
// Bench for fifo_uart_tx: two instances (1 and 2 stop bits) driven by shared
// stimulus, each with a queue-based FIFO and a frame-timeline reference model.
module tb_fifo_uart_tx;
  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       reset, enable, push_en;
  logic [7:0] push_data;
  logic [1:0] tx_w, busy_w, fd_w, rr_w, empty_w;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : u
    localparam int SB = g + 1;

    fifo_uart_tx_if #(.DATAWIDTH(8)) bus ();

    fifo_uart_tx #(.DATAWIDTH(8), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .fifo       (bus),
      .tx         (tx_w[g]),
      .busy       (busy_w[g]),
      .frame_done (fd_w[g])
    );

    assign rr_w[g]    = bus.fifo_read_req;
    assign empty_w[g] = bus.fifo_empty;

    logic [7:0] q     [$];
    logic [3:0] sched [$];  // {tx, busy, read_req, frame_done} for upcoming cycles
    logic       armed = 1'b0;
    logic [7:0] w;
    logic       v;
    logic [3:0] exp;

    // FIFO stand-in: pop on the strobe, data valid from the following cycle.
    always @(negedge clk) begin
      if (bus.fifo_read_req === 1'b1) begin
        check($sformatf("pop_nonempty%0d", g), q.size() > 0, 1);
        if (q.size() > 0) bus.fifo_data = q.pop_front();
      end
      if (push_en) q.push_back(push_data);
      bus.fifo_empty = (q.size() == 0);
    end

    // Reference: a started frame is a fixed timeline of per-cycle outputs.
    always @(posedge clk) begin
      if (reset) begin
        sched.delete();
        armed <= 1'b1;
      end else if (sched.size() == 0) begin
        if (enable && q.size() > 0) begin
          w = q[0];
          sched.push_back(4'b1110);
          sched.push_back(4'b1100);
          for (int b = 0; b < 9 + SB; b++) begin
            if (b == 0)      v = 1'b0;
            else if (b <= 8) v = w[b-1];
            else             v = 1'b1;
            for (int c = 0; c < CPB; c++)
              sched.push_back({v, 1'b1, 1'b0, (b == 8 + SB) && (c == CPB - 1)});
          end
        end
      end else begin
        void'(sched.pop_front());
      end
    end

    always @(negedge clk) begin
      if (armed) begin
        exp = (sched.size() > 0) ? sched[0] : 4'b1000;
        check($sformatf("tx%0d", g),         tx_w[g],   exp[3]);
        check($sformatf("busy%0d", g),       busy_w[g], exp[2]);
        check($sformatf("read_req%0d", g),   rr_w[g],   exp[1]);
        check($sformatf("frame_done%0d", g), fd_w[g],   exp[0]);
      end
    end
  end

  bit [1:0]   log_tx [$];
  bit [1:0]   log_fd [$];
  int         rr_cnt [2];
  int         fd_cnt [2];
  logic [1:0] last_tx, last_busy, last_rr, last_fd;

  task automatic step();
    @(negedge clk);
    log_tx.push_back(tx_w);
    log_fd.push_back(fd_w);
    for (int i = 0; i < 2; i++) begin
      rr_cnt[i] += int'(rr_w[i]);
      fd_cnt[i] += int'(fd_w[i]);
    end
    last_tx   = tx_w;
    last_busy = busy_w;
    last_rr   = rr_w;
    last_fd   = fd_w;
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    repeat (n) step();
  endtask

  task automatic clear_logs();
    log_tx.delete();
    log_fd.delete();
    rr_cnt = '{0, 0};
    fd_cnt = '{0, 0};
  endtask

  task automatic push(input logic [7:0] d);
    push_en   = 1'b1;
    push_data = d;
    step();
    push_en   = 1'b0;
  endtask

  function automatic int first_low(input int i, input int from);
    for (int k = from; k < log_tx.size(); k++) if (log_tx[k][i] == 1'b0) return k;
    return -1;
  endfunction

  function automatic int last_low_before(input int i, input int upto);
    for (int k = upto; k >= 0; k--) if (log_tx[k][i] == 1'b0) return k;
    return -1;
  endfunction

  function automatic int next_fd(input int i, input int from);
    for (int k = from; k < log_fd.size(); k++) if (log_fd[k][i] == 1'b1) return k;
    return -1;
  endfunction

  function automatic int low_count(input int i);
    int n = 0;
    for (int k = 0; k < log_tx.size(); k++) if (log_tx[k][i] == 1'b0) n++;
    return n;
  endfunction

  initial begin
    int         fl, fd, f1, f2, n1, n2, l;
    logic [9:0] bits;
    logic [7:0] word;

    reset     = 1'b1;
    enable    = 1'b0;
    push_en   = 1'b0;
    push_data = '0;

    // Reset values
    steps(2);
    reset = 1'b0;
    step();
    check("rst_tx", last_tx, 2'b11);
    check("rst_busy", last_busy, 2'b00);
    check("rst_rr", last_rr, 2'b00);
    check("rst_fd", last_fd, 2'b00);

    // Single frame of 0xA5
    push(8'hA5);
    clear_logs();
    enable = 1'b1;
    steps(60);
    fl = first_low(0, 0);
    check("a5_first_low", fl, 3);
    if (fl >= 0) begin
      for (int i = 0; i < 10; i++) bits[i] = log_tx[fl + 4 * i + 1][0];
      check("a5_bits", bits, 10'b1101001010);
      check("a5_len0", next_fd(0, 0) - fl + 1, 40);
    end
    check("a5_len1", next_fd(1, 0) - first_low(1, 0) + 1, 44);
    check("a5_pops", rr_cnt[0], 1);
    check("a5_done", fd_cnt[0], 1);
    check("a5_empty", empty_w, 2'b11);

    // Back-to-back frames
    enable = 1'b0;
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    clear_logs();
    enable = 1'b1;
    steps(150);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("b2b_pops%0d", i), rr_cnt[i], 3);
      check($sformatf("b2b_done%0d", i), fd_cnt[i], 3);
      f1 = next_fd(i, 0);
      n1 = first_low(i, f1 + 1);
      f2 = next_fd(i, f1 + 1);
      n2 = first_low(i, f2 + 1);
      check($sformatf("b2b_gap1_%0d", i), n1 - f1 - 1, 3);
      check($sformatf("b2b_gap2_%0d", i), n2 - f2 - 1, 3);
      if (n2 >= 0) begin
        for (int j = 0; j < 8; j++) word[j] = log_tx[n2 + 4 * (j + 1) + 1][i];
        check($sformatf("b2b_word3_%0d", i), word, 8'h3C);
      end
    end
    check("b2b_empty", empty_w, 2'b11);

    // Empty / enable gating
    clear_logs();
    steps(50);
    check("gate_empty_pops", rr_cnt[0] + rr_cnt[1], 0);
    check("gate_empty_lows", low_count(0) + low_count(1), 0);
    enable = 1'b0;
    push(8'h5A);
    clear_logs();
    steps(20);
    check("gate_disabled_pops", rr_cnt[0] + rr_cnt[1], 0);
    clear_logs();
    enable = 1'b1;
    steps(60);
    check("gate_start0", first_low(0, 0), 3);
    check("gate_start1", first_low(1, 0), 3);

    // Reset during data bit 3 of 0x55
    enable = 1'b0;
    push(8'h55);
    clear_logs();
    enable = 1'b1;
    steps(20);
    check("mid_bit3", last_tx, 2'b00);
    reset = 1'b1;
    step();
    reset = 1'b0;
    step();
    check("mid_rst_tx", last_tx, 2'b11);
    check("mid_rst_busy", last_busy, 2'b00);
    clear_logs();
    steps(50);
    check("mid_quiet_pops", rr_cnt[0] + rr_cnt[1], 0);
    check("mid_quiet_lows", low_count(0) + low_count(1), 0);

    // Enable dropped mid-frame, stop period per instance
    enable = 1'b0;
    push(8'h55);
    push(8'h0F);
    clear_logs();
    enable = 1'b1;
    steps(10);
    enable = 1'b0;
    steps(70);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("drop_pops%0d", i), rr_cnt[i], 1);
      check($sformatf("drop_done%0d", i), fd_cnt[i], 1);
      fd = next_fd(i, 0);
      l  = last_low_before(i, fd);
      check($sformatf("drop_stop_len%0d", i), fd - l, 4 * (i + 1));
    end
    check("drop_left_word", empty_w, 2'b00);

    // Randomized traffic against the reference models
    enable = 1'b1;
    for (int k = 0; k < 1500; k++) begin
      push_en   = ($urandom_range(0, 39) == 0);
      push_data = 8'($urandom);
      reset     = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) enable = ~enable;
      step();
    end
    push_en = 1'b0;
    reset   = 1'b0;
    steps(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
